// File: rtl/mac_seq_ctrl_if.sv
// Command channel between the pin-level host logic and the MAC sequencer.
// The host drives a valid/op/data transaction and the sequencer answers with ready.
interface mac_seq_ctrl_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for an iterative shift-add MAC datapath.
// Latches operands from host commands, walks the datapath through
// load -> W steps -> commit (or load -> commit when B is zero), and keeps a
// saturating count of committed MACs. ena=0 freezes the whole sequence.
module mac_seq_ctrl #(
  parameter  int W     = 8,
  parameter  int CNT_W = 4,
  localparam int IDX_W = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  mac_seq_ctrl_if.slave     cmd,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mac_count,
  output logic              cnt_sat,
  output logic [W-1:0]      dp_op_a,
  output logic [W-1:0]      dp_op_b,
  output logic              dp_load,
  output logic              dp_step,
  output logic [IDX_W-1:0]  dp_bit_idx,
  output logic              dp_commit,
  output logic              dp_clr
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  localparam logic [1:0]       OP_LOAD_A = 2'b00;
  localparam logic [1:0]       OP_RUN    = 2'b01;
  localparam logic [1:0]       OP_CLEAR  = 2'b10;
  localparam logic [1:0]       OP_RERUN  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(W - 1);

  state_e           state_q,   state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [W-1:0]     op_a_q,    op_a_d;
  logic [W-1:0]     op_b_q,    op_b_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             xfer_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      count_q   <= count_d;
    end
  end

  // Next-state and register-update logic; everything holds while ena is low.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    count_d   = count_q;
    // Ready is only ever high in IDLE with ena, so a transfer is decoded
    // from state rather than from the ready output itself.
    xfer_s    = cmd.cmd_valid & (state_q == ST_IDLE) & ena;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (xfer_s) begin
            case (cmd.cmd_op)
              OP_LOAD_A: op_a_d = cmd.cmd_data;
              OP_RUN: begin
                op_b_d  = cmd.cmd_data;
                state_d = ST_LOAD;
              end
              OP_CLEAR:  state_d = ST_CLEAR;
              OP_RERUN:  state_d = ST_LOAD;
              default:   state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          // A zero multiplier contributes nothing, so skip the step phase.
          if (op_b_q == '0) begin
            state_d = ST_COMMIT;
          end else begin
            bit_idx_d = '0;
            state_d   = ST_STEP;
          end
        end
        ST_STEP: begin
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = ST_COMMIT;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            state_d   = ST_STEP;
          end
        end
        ST_COMMIT: begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_q;
          end
          state_d = ST_IDLE;
        end
        ST_CLEAR: begin
          count_d = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from registered state only; ena gates every strobe so a
  // frozen sequence fires its pending strobe exactly once on resume.
  always_comb begin
    dp_load       = 1'b0;
    dp_step       = 1'b0;
    dp_commit     = 1'b0;
    dp_clr        = 1'b0;
    done          = 1'b0;
    busy          = (state_q != ST_IDLE);
    cmd.cmd_ready = (state_q == ST_IDLE) & ena;
    dp_bit_idx    = bit_idx_q;
    dp_op_a       = op_a_q;
    dp_op_b       = op_b_q;
    mac_count     = count_q;
    cnt_sat       = (count_q == CNT_MAX);

    if (ena) begin
      case (state_q)
        ST_LOAD:   dp_load = 1'b1;
        ST_STEP:   dp_step = 1'b1;
        ST_COMMIT: begin
          dp_commit = 1'b1;
          done      = 1'b1;
        end
        ST_CLEAR:  dp_clr = 1'b1;
        default:   dp_load = 1'b0;
      endcase
    end else begin
      dp_load = 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed scenarios followed by random traffic,
// compared every cycle against an event-list model of the sequencer.
module tb_mac_seq_ctrl;
  localparam int W       = 8;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 3;
  localparam int CNT_MAX = 15;

  localparam int EV_LOAD   = 100;
  localparam int EV_COMMIT = 200;
  localparam int EV_CLR    = 300;

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_RERUN  = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] mac_count;
  logic             cnt_sat;
  logic [W-1:0]     dp_op_a;
  logic [W-1:0]     dp_op_b;
  logic             dp_load;
  logic             dp_step;
  logic [IDX_W-1:0] dp_bit_idx;
  logic             dp_commit;
  logic             dp_clr;

  mac_seq_ctrl_if #(.W(W)) cmd_if ();

  mac_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd        (cmd_if.slave),
    .busy       (busy),
    .done       (done),
    .mac_count  (mac_count),
    .cnt_sat    (cnt_sat),
    .dp_op_a    (dp_op_a),
    .dp_op_b    (dp_op_b),
    .dp_load    (dp_load),
    .dp_step    (dp_step),
    .dp_bit_idx (dp_bit_idx),
    .dp_commit  (dp_commit),
    .dp_clr     (dp_clr)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  // Model: the ordered list of strobe events still owed by the sequencer.
  int           ev_q[$];
  logic [W-1:0] a_m;
  logic [W-1:0] b_m;
  int           cnt_m;
  bit           model_ok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_mac();
    ev_q.push_back(EV_LOAD);
    if (b_m != '0) begin
      for (int i = 0; i < W; i++) ev_q.push_back(i);
    end
    ev_q.push_back(EV_COMMIT);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then advance the model by what the rising edge will do.
  task automatic cyc(input logic r, input logic e, input logic v,
                     input logic [1:0] op, input logic [W-1:0] d);
    int head;
    bit has;
    rst_n            = r;
    ena              = e;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    @(negedge clk);
    if (model_ok) begin
      has  = (ev_q.size() > 0);
      head = has ? ev_q[0] : -1;
      chk("busy",   busy,             32'(has));
      chk("ready",  cmd_if.cmd_ready, 32'(!has && e));
      chk("load",   dp_load,          32'(e && head == EV_LOAD));
      chk("step",   dp_step,          32'(e && has && head < W));
      if (has && head < W) chk("bit_idx", dp_bit_idx, 32'(head));
      chk("commit", dp_commit,        32'(e && head == EV_COMMIT));
      chk("done",   done,             32'(e && head == EV_COMMIT));
      chk("clr",    dp_clr,           32'(e && head == EV_CLR));
      chk("count",  mac_count,        32'(cnt_m));
      chk("sat",    cnt_sat,          32'(cnt_m == CNT_MAX));
      chk("op_a",   dp_op_a,          32'(a_m));
      chk("op_b",   dp_op_b,          32'(b_m));
    end
    if (!r) begin
      ev_q.delete();
      a_m      = '0;
      b_m      = '0;
      cnt_m    = 0;
      model_ok = 1'b1;
    end else if (e && model_ok) begin
      if (ev_q.size() > 0) begin
        head = ev_q.pop_front();
        if (head == EV_COMMIT) cnt_m = (cnt_m == CNT_MAX) ? cnt_m : cnt_m + 1;
        else if (head == EV_CLR) cnt_m = 0;
      end else if (v) begin
        case (op)
          OP_LOAD_A: a_m = d;
          OP_RUN: begin
            b_m = d;
            push_mac();
          end
          OP_RERUN:  push_mac();
          default:   ev_q.push_back(EV_CLR);
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, OP_LOAD_A, 8'h00);
  endtask

  initial begin
    logic [W-1:0] rd;
    rst_n            = 1'b0;
    ena              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD_A;
    cmd_if.cmd_data  = 8'h00;
    @(posedge clk);
    #1;

    // Reset held two cycles, then ready must come straight up.
    cyc(1'b0, 1'b1, 1'b0, OP_LOAD_A, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, OP_LOAD_A, 8'h00);
    idle(2);

    // LOAD_A 0x05, RUN 0x03: full eight-step MAC.
    cyc(1'b1, 1'b1, 1'b1, OP_LOAD_A, 8'h05);
    cyc(1'b1, 1'b1, 1'b1, OP_RUN,    8'h03);
    idle(12);

    // Zero multiplier: load then commit, no steps.
    cyc(1'b1, 1'b1, 1'b1, OP_RUN, 8'h00);
    idle(4);

    // RUN held valid while busy must only be taken once ready returns.
    cyc(1'b1, 1'b1, 1'b1, OP_RUN, 8'h81);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b1, OP_RUN, 8'h42);
    idle(12);

    // Back-to-back RERUNs push the counter into saturation, then CLEAR.
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, 1'b1, OP_RERUN, 8'h00);
    idle(12);
    cyc(1'b1, 1'b1, 1'b1, OP_CLEAR, 8'h00);
    idle(3);

    // Reset during the step with bit index 4.
    cyc(1'b1, 1'b1, 1'b1, OP_RUN, 8'hFF);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0, OP_LOAD_A, 8'h00);
    idle(3);

    // Freeze mid-step and resume.
    cyc(1'b1, 1'b1, 1'b1, OP_RUN, 8'h5A);
    idle(4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, OP_CLEAR, 8'h00);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      cyc(logic'($urandom_range(99) != 0), logic'($urandom_range(9) != 0),
          logic'($urandom_range(1)), 2'($urandom_range(3)), rd);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
